mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a single-outstanding bus.
// Handles alignment rejection, byte-lane steering, load extension and bus timeout.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [7:0]  r_cnt;
  logic        r_timeout_err;
  logic        w_idle_req;
  logic        w_aligned;
  logic        w_accept;

  // Sizes: funct3[1:0] 00 byte, 01 half, anything else behaves as word.
  function automatic logic is_aligned(input logic [2:0] f, input logic [1:0] a);
    case (f[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [2:0] f, input logic [1:0] a);
    case (f[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f, input logic [31:0] d);
    case (f[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] f, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // Requests are only honoured in IDLE and never while reset is held.
  assign w_idle_req = (r_state == S_IDLE) & (mem_read | mem_write) & ~reset;
  assign w_aligned  = is_aligned(funct3, addr[1:0]);
  assign w_accept   = w_idle_req & w_aligned;

  assign stall       = w_accept | (r_state == S_BUSY);
  assign misalign    = w_idle_req & ~w_aligned;
  assign timeout_err = r_timeout_err;
  assign bus_req     = (r_state == S_BUSY);
  assign bus_we      = bus_req & r_we;
  assign bus_addr    = {r_addr[31:2], 2'b00};
  assign bus_wstrb   = bus_we ? lane_strobe(r_funct3, r_addr[1:0]) : 4'b0000;
  assign bus_wdata   = lane_wdata(r_funct3, r_store_data);

  // Next-state logic; bus_ready wins over a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_BUSY;
        else          w_next = S_IDLE;
      end
      S_BUSY: begin
        if (bus_ready)                  w_next = S_DONE;
        else if (r_cnt == TIMEOUT_LAST) w_next = S_DONE;
        else                            w_next = S_BUSY;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latched request, wait counter, load result and timeout pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= 32'h0000_0000;
      r_store_data  <= 32'h0000_0000;
      r_funct3      <= 3'b000;
      r_we          <= 1'b0;
      r_cnt         <= 8'h00;
      r_timeout_err <= 1'b0;
      load_data     <= 32'h0000_0000;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr       <= addr;
            r_store_data <= store_data;
            r_funct3     <= funct3;
            r_we         <= mem_write;
            r_cnt        <= 8'h00;
          end
        end
        S_BUSY: begin
          if (bus_ready) begin
            if (!r_we) load_data <= extract_load(r_funct3, r_addr[1:0], bus_rdata);
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_timeout_err <= 1'b1;
            load_data     <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + 8'h01;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit built with TIMEOUT=4.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, misalign, timeout_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
    .stall(stall), .misalign(misalign), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    #3;
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rst_load got=%h exp=%h", load_data, 32'h0); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (misalign !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", misalign, timeout_err); end
    total++; if (bus_wstrb !== 4'b0000 || bus_we !== 1'b0) begin bad++; $display("FAIL rst_wstrb got=%b/%b exp=0000/0", bus_wstrb, bus_we); end
    cyc(); cyc();
    reset = 1'b0;
    #4;
    total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_release got=%b%b exp=00", bus_req, stall); end
  endtask

  task automatic test_lb_zero_wait();
    cyc(); mem_read = 1'b1; funct3 = 3'b000; addr = 32'h103;
    #4;
    total++; if (stall !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL lb_req_cycle got=%b%b exp=10", stall, bus_req); end
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h80FF_FF7F;
    #4;
    total++; if (stall !== 1'b1 || bus_req !== 1'b1) begin bad++; $display("FAIL lb_busy got=%b%b exp=11", stall, bus_req); end
    total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=%h", bus_addr, 32'h100); end
    total++; if (bus_we !== 1'b0 || bus_wstrb !== 4'b0000) begin bad++; $display("FAIL lb_we got=%b/%b exp=0/0000", bus_we, bus_wstrb); end
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL lb_done got=%b%b exp=00", stall, bus_req); end
    total++; if (load_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=%h", load_data, 32'hFFFF_FF80); end
  endtask

  task automatic test_lhu_waits();
    cyc(); mem_read = 1'b1; funct3 = 3'b101; addr = 32'h102;
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lhu_stall got=%b exp=1", stall); end
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_read = 1'b0;
      #4;
      total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100 || stall !== 1'b1) begin
        bad++; $display("FAIL lhu_wait%0d got=%b/%h/%b exp=1/00000100/1", i, bus_req, bus_addr, stall);
      end
    end
    cyc(); bus_ready = 1'b1; bus_rdata = 32'hBEEF_1234;
    #4;
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL lhu_ready got=%b/%h exp=1/00000100", bus_req, bus_addr); end
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_data got=%h exp=%h", load_data, 32'h0000_BEEF); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL lhu_no_timeout got=%b exp=0", timeout_err); end
  endtask

  task automatic test_stores();
    cyc(); mem_write = 1'b1; funct3 = 3'b000; addr = 32'h21; store_data = 32'h0000_00AB;
    #4;
    cyc(); mem_write = 1'b0; bus_ready = 1'b1;
    #4;
    total++; if (bus_we !== 1'b1 || bus_wstrb !== 4'b0010) begin bad++; $display("FAIL sb_strb got=%b/%b exp=1/0010", bus_we, bus_wstrb); end
    total++; if (bus_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=%h", bus_wdata, 32'hABAB_ABAB); end
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'h0000_BEEF) begin bad++; $display("FAIL sb_load_kept got=%h exp=%h", load_data, 32'h0000_BEEF); end
    total++; if (bus_we !== 1'b0 || bus_wstrb !== 4'b0000) begin bad++; $display("FAIL sb_idle_we got=%b/%b exp=0/0000", bus_we, bus_wstrb); end
    // Both request lines high: must be treated as a store.
    cyc(); mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h22; store_data = 32'h1234_CDEF;
    #4;
    cyc(); mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
    #4;
    total++; if (bus_we !== 1'b1 || bus_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_strb got=%b/%b exp=1/1100", bus_we, bus_wstrb); end
    total++; if (bus_wdata !== 32'hCDEF_CDEF || bus_addr !== 32'h20) begin bad++; $display("FAIL sh_wdata got=%h/%h exp=cdefcdef/00000020", bus_wdata, bus_addr); end
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'h0000_BEEF) begin bad++; $display("FAIL sh_load_kept got=%h exp=%h", load_data, 32'h0000_BEEF); end
  endtask

  task automatic test_load_ext();
    cyc(); mem_read = 1'b1; funct3 = 3'b001; addr = 32'h200;
    #4;
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h1234_8001;
    #4;
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%h exp=%h", load_data, 32'hFFFF_8001); end
    cyc(); mem_read = 1'b1; funct3 = 3'b100; addr = 32'h201;
    #4;
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0000_9A00;
    #4;
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'h0000_009A) begin bad++; $display("FAIL lbu_data got=%h exp=%h", load_data, 32'h0000_009A); end
  endtask

  task automatic test_misalign();
    cyc(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102;
    #4;
    total++; if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
      bad++; $display("FAIL lw_misalign got=%b%b%b exp=100", misalign, stall, bus_req);
    end
    cyc(); mem_read = 1'b0;
    #4;
    total++; if (misalign !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL lw_misalign_after got=%b%b exp=00", misalign, bus_req); end
    total++; if (load_data !== 32'h0000_009A) begin bad++; $display("FAIL lw_misalign_load got=%h exp=%h", load_data, 32'h0000_009A); end
    cyc(); mem_write = 1'b1; funct3 = 3'b001; addr = 32'h101;
    #4;
    total++; if (misalign !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL sh_misalign got=%b%b exp=10", misalign, stall); end
    cyc(); mem_write = 1'b0;
    #4;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL sh_misalign_req got=%b exp=0", bus_req); end
  endtask

  task automatic test_timeout();
    int n_req;
    n_req = 0;
    cyc(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h104; bus_ready = 1'b0;
    #4;
    for (int i = 0; i < 20; i++) begin
      cyc(); mem_read = 1'b0;
      #4;
      if (!bus_req) break;
      n_req++;
    end
    total++; if (n_req !== 4) begin bad++; $display("FAIL to_req_cycles got=%0d exp=4", n_req); end
    total++; if (timeout_err !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b%b exp=10", timeout_err, stall); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL to_load got=%h exp=%h", load_data, 32'h0); end
    cyc();
    #4;
    total++; if (timeout_err !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL to_after got=%b%b exp=00", timeout_err, bus_req); end
  endtask

  task automatic test_reset_mid_busy();
    cyc(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
    #4;
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #4;
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL pre_rst_load got=%h exp=%h", load_data, 32'hCAFE_F00D); end
    cyc(); mem_read = 1'b1; addr = 32'h20;
    #4;
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h5555_5555; reset = 1'b1;
    #1;
    total++; if (bus_req !== 1'b0 || load_data !== 32'h0) begin bad++; $display("FAIL rst_busy got=%b/%h exp=0/00000000", bus_req, load_data); end
    cyc();
    #4;
    total++; if (load_data !== 32'h0 || stall !== 1'b0) begin bad++; $display("FAIL rst_ready_ignored got=%h/%b exp=00000000/0", load_data, stall); end
    cyc(); reset = 1'b0; bus_ready = 1'b0;
    #4;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", bus_req); end
    cyc(); mem_read = 1'b1; addr = 32'h40;
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL post_rst_stall got=%b exp=1", stall); end
    cyc(); mem_read = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h1122_3344;
    #4;
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin bad++; $display("FAIL post_rst_bus got=%b/%h exp=1/00000040", bus_req, bus_addr); end
    cyc(); bus_ready = 1'b0;
    #4;
    total++; if (load_data !== 32'h1122_3344) begin bad++; $display("FAIL post_rst_load got=%h exp=%h", load_data, 32'h1122_3344); end
  endtask

  initial begin
    test_reset();
    test_lb_zero_wait();
    test_lhu_waits();
    test_stores();
    test_load_ext();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
